timer_irq_sched: RTL and testbench
==================================

# timer_irq_sched

Priority scheduler between the programmable timer peripherals and the core's interrupt entry. It latches the `interrupt_set` lines of up to `NumTimers` timers and arbitrates among them using per-timer priorities held in one CSR. It presents the winner to the core with a req/ack handshake, pulses the winning timer's `interrupt_clear`, and tracks nested preemption on a priority stack that is popped on return.

## Interface
- `NumTimers`, 4: number of timer sources, 2..8.
- `PrioWidth`, 3: priority field width; priority 0 means the source is disabled.
- `Depth`, 4: nesting stack depth.
- `Addr`, `CsrAddrT'(TimerSchedAddr)`: CSR address of the priority register.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `csr_enable`  in  1: CSR access strobe.
- `csr_addr`  in  `CsrAddrT`: CSR address.
- `csr_op`  in  `csr_op_t`: CSR operation (RW/RS/RC and immediate variants).
- `rs1_zimm`  in  `r`: zero-extended immediate for immediate ops.
- `rs1_data`  in  `word`: register operand.
- `csr_out`  out  `word`: current priority register, zero-extended.
- `timer_irq`  in  `NumTimers`: `interrupt_set` from each timer.
- `timer_clear`  out  `NumTimers`: `interrupt_clear` to each timer; one-hot pulse.
- `irq_req`  out  1: interrupt request to the core.
- `irq_id`  out  `$clog2(NumTimers)`: index of the requesting timer.
- `irq_prio`  out  `PrioWidth`: priority of the request.
- `irq_ack`  in  1: core takes the request.
- `irq_ret`  in  1: core returns from a handler (mret).
- `cur_prio`  out  `PrioWidth`: top of the stack; 0 when the stack is empty.

## Operation
- **Priority register:** `NumTimers*PrioWidth` bits. Field i is `[i*PrioWidth +: PrioWidth]`, the priority of timer i. Upper bits read 0.
- **CSR writes:** applied when `csr_enable && csr_addr==Addr`.
  - RW replaces the register; RS ORs the operand in; RC clears operand bits.
  - The operand is `rs1_data`, or `rs1_zimm` for immediate ops.
  - Bits beyond the register width are ignored.
- **Pending:** `pending[i]` sets on a rising edge of `timer_irq[i]`, detected against a registered copy. It clears when source i is acked. If a new edge and an ack of source i occur in the same cycle, set wins.
- **Eligibility:** source i is eligible when `pending[i]`, `prio[i]!=0`, `prio[i]>cur_prio`, and the stack is not full.
- **Winner:** highest priority among eligible sources; equal priorities go to the lowest index.
- **FSM states:**
  - IDLE: if any source is eligible, register the winner into `irq_id`/`irq_prio`, set `irq_req`, go to REQ.
  - REQ: `irq_id`/`irq_prio` stay frozen, even if a higher source arrives or the CSR changes. On `irq_ack`: push `irq_prio`, clear `pending[irq_id]`, pulse `timer_clear[irq_id]`, drop `irq_req`, go to IDLE.
- **`irq_ret`:** pops the stack in any state. It is ignored when the stack is empty.
- **Ack and return in the same cycle:** pop first, then push, so the depth is unchanged and the top becomes `irq_prio`.
- **Stack full:** no new request is issued until a return.
- **`irq_ack` in IDLE:** ignored.

## Timing
- **Reset values:** priority register 0, pending 0, stack empty, state IDLE. Outputs reset as `irq_req=0`, `irq_id=0`, `irq_prio=0`, `cur_prio=0`, `timer_clear=0`.
- **Request latency:** `timer_irq[i]` first sampled high at edge n → `pending[i]` high after n → `irq_req` high after edge n+1. Request latency is 2 cycles.
- **Ack:** `irq_ack` sampled at edge m → after m, `irq_req=0`, `timer_clear[irq_id]=1` for exactly one cycle, and `cur_prio` is updated. The earliest next request is after edge m+1.
- **Return:** `irq_ret` at edge m → `cur_prio` updates after m. A newly eligible lower source can request after m+1.
- **CSR:** a write at edge m takes effect after m. `csr_out` is combinational from the register. A write and an arbitration decision in the same cycle use the old value.
- **Mid-operation reset:** asserting `reset` mid-operation returns everything to reset values immediately (asynchronously). A `timer_irq` held high through reset deassertion counts as a rising edge, because the registered copy resets to 0.

## Test plan
- **Basic request:** prio reg=0x00A (T0=2, T1=1); rise T1 at cycle 10 → `irq_req=1`, `irq_id=1`, `irq_prio=1` at cycle 12. Ack at 14 → `timer_clear=4'b0010` for one cycle, `cur_prio=1`.
- **Priority and tie-break:** T0 and T2 rise together, both prio 3 → `irq_id=0`. After ack and return, `irq_id=2` follows.
- **Preemption and masking:** in T1's handler (`cur_prio=1`), rise T0 (prio 2) → request issued. With `cur_prio=2`, rise T3 (prio 2) → no request until `irq_ret`, after which `irq_req=1`, `irq_id=3`.
- **Stack full:** `Depth=4`, four nested acks at prios 1..4, T with prio 5 pending → no `irq_req`. One `irq_ret` → request within 2 cycles.
- **CSR ops:** RS with zimm 0x3 then RC with 0x1 → `csr_out=0x2`. Setting prio to 0 disables a pending source (no request). Re-enabling it requests with the still-latched pending bit.
- **Simultaneous events and reset:** ack and return in the same cycle → depth unchanged, `cur_prio=irq_prio`. Reset asserted while `irq_req=1` → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/timer_irq_sched.sv
// Timer interrupt priority scheduler: latches timer interrupt edges, arbitrates by
// CSR-programmed priority, hands the winner to the core and tracks nesting on a stack.
package timer_irq_sched_pkg;
  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  zimm_t;

  localparam csr_addr_t TimerSchedAddr = 12'h7C0;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_t;
endpackage

module timer_irq_sched
  import timer_irq_sched_pkg::*;
#(
  parameter int unsigned NumTimers = 4,
  parameter int unsigned PrioWidth = 3,
  parameter int unsigned Depth     = 4,
  parameter csr_addr_t   Addr      = csr_addr_t'(TimerSchedAddr)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         csr_enable,
  input  csr_addr_t                    csr_addr,
  input  csr_op_t                      csr_op,
  input  zimm_t                        rs1_zimm,
  input  word_t                        rs1_data,
  output word_t                        csr_out,
  input  logic [NumTimers-1:0]         timer_irq,
  output logic [NumTimers-1:0]         timer_clear,
  output logic                         irq_req,
  output logic [$clog2(NumTimers)-1:0] irq_id,
  output logic [PrioWidth-1:0]         irq_prio,
  input  logic                         irq_ack,
  input  logic                         irq_ret,
  output logic [PrioWidth-1:0]         cur_prio
);

  localparam int unsigned IdW  = $clog2(NumTimers);
  localparam int unsigned RegW = NumTimers * PrioWidth;
  localparam int unsigned SpW  = $clog2(Depth + 1);
  localparam int unsigned StkW = $clog2(Depth);
  localparam logic [SpW-1:0] DepthSp = SpW'(Depth);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [RegW-1:0]      prio_q, prio_d;
  logic [NumTimers-1:0] irq_prev_q;
  logic [NumTimers-1:0] pending_q, pending_d;
  logic [NumTimers-1:0] timer_clear_q, timer_clear_d;
  logic [IdW-1:0]       irq_id_q, irq_id_d;
  logic [PrioWidth-1:0] irq_prio_q, irq_prio_d;
  logic [PrioWidth-1:0] stack_q [Depth];
  logic [PrioWidth-1:0] stack_d [Depth];
  logic [SpW-1:0]       sp_q, sp_d;

  logic [PrioWidth-1:0] prio_f [NumTimers];
  logic [NumTimers-1:0] eligible;
  logic [NumTimers-1:0] pending_clr;
  logic                 stack_full;
  logic                 push;
  logic                 pop;
  logic                 any_eligible;
  logic [IdW-1:0]       win_id;
  logic [PrioWidth-1:0] win_prio;
  logic [PrioWidth-1:0] top_prio;

  logic [2:0]           op_bits;
  word_t                operand;
  logic [RegW-1:0]      operand_reg;
  logic                 unused_operand_bits;

  // ---------------------------------------------------------------------------
  // Priority CSR
  // ---------------------------------------------------------------------------
  always_comb begin
    op_bits     = csr_op;
    operand     = op_bits[2] ? word_t'(rs1_zimm) : rs1_data;
    operand_reg = RegW'(operand);
    prio_d      = prio_q;
    if (csr_enable && (csr_addr == Addr)) begin
      case (op_bits[1:0])
        2'b01:   prio_d = operand_reg;
        2'b10:   prio_d = prio_q | operand_reg;
        2'b11:   prio_d = prio_q & ~operand_reg;
        default: prio_d = prio_q;
      endcase
    end
  end

  assign unused_operand_bits = ^operand;
  assign csr_out             = word_t'(prio_q);

  // ---------------------------------------------------------------------------
  // Stack view and per-source eligibility
  // ---------------------------------------------------------------------------
  assign top_prio   = stack_q[StkW'(sp_q - SpW'(1))];
  assign cur_prio   = (sp_q == '0) ? '0 : top_prio;
  assign stack_full = (sp_q == DepthSp);

  for (genvar gi = 0; gi < NumTimers; gi++) begin : g_src
    assign prio_f[gi]   = prio_q[gi*PrioWidth +: PrioWidth];
    assign eligible[gi] = pending_q[gi] && (prio_f[gi] != '0) &&
                          (prio_f[gi] > cur_prio) && !stack_full;
  end

  // Strict '>' while scanning upward keeps the lowest index on equal priorities.
  always_comb begin
    any_eligible = 1'b0;
    win_id       = '0;
    win_prio     = '0;
    for (int i = 0; i < NumTimers; i++) begin
      if (eligible[i] && (prio_f[i] > win_prio)) begin
        any_eligible = 1'b1;
        win_id       = IdW'(i);
        win_prio     = prio_f[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request/acknowledge FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    irq_id_d      = irq_id_q;
    irq_prio_d    = irq_prio_q;
    timer_clear_d = '0;
    pending_clr   = '0;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d    = ST_REQ;
          irq_id_d   = win_id;
          irq_prio_d = win_prio;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d       = ST_IDLE;
          push          = 1'b1;
          pending_clr   = NumTimers'(1) << irq_id_q;
          timer_clear_d = NumTimers'(1) << irq_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the same cycle as the ack keeps the source pending.
  assign pending_d = (pending_q & ~pending_clr) | (timer_irq & ~irq_prev_q);

  // Pop before push so a simultaneous ack/return replaces the top in place.
  always_comb begin
    stack_d = stack_q;
    sp_d    = sp_q;
    pop     = irq_ret && (sp_q != '0);
    if (pop) begin
      sp_d = sp_q - SpW'(1);
    end
    if (push && (sp_d != DepthSp)) begin
      stack_d[StkW'(sp_d)] = irq_prio_q;
      sp_d                 = sp_d + SpW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      prio_q        <= '0;
      irq_prev_q    <= '0;
      pending_q     <= '0;
      timer_clear_q <= '0;
      irq_id_q      <= '0;
      irq_prio_q    <= '0;
      sp_q          <= '0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      irq_prev_q    <= timer_irq;
      pending_q     <= pending_d;
      timer_clear_q <= timer_clear_d;
      irq_id_q      <= irq_id_d;
      irq_prio_q    <= irq_prio_d;
      sp_q          <= sp_d;
    end
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_stack
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stack_q[gi] <= '0;
      end else begin
        stack_q[gi] <= stack_d[gi];
      end
    end
  end

  assign irq_req     = (state_q == ST_REQ);
  assign irq_id      = irq_id_q;
  assign irq_prio    = irq_prio_q;
  assign timer_clear = timer_clear_q;

endmodule

// File: tb/tb_timer_irq_sched.sv
// Directed self-checking bench for timer_irq_sched: request latency, arbitration,
// nesting/preemption, stack full, CSR ops, simultaneous ack/return and async reset.
module tb_timer_irq_sched;
  import timer_irq_sched_pkg::*;

  localparam csr_addr_t ADDR = 12'h7C0;

  logic       clk;
  logic       reset;
  logic       csr_enable;
  csr_addr_t  csr_addr;
  csr_op_t    csr_op;
  zimm_t      rs1_zimm;
  word_t      rs1_data;
  word_t      csr_out;
  logic [3:0] timer_irq;
  logic [3:0] timer_clear;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [2:0] irq_prio;
  logic       irq_ack;
  logic       irq_ret;
  logic [2:0] cur_prio;

  int n_checks = 0;
  int n_errors = 0;

  timer_irq_sched dut (
    .clk        (clk),
    .reset      (reset),
    .csr_enable (csr_enable),
    .csr_addr   (csr_addr),
    .csr_op     (csr_op),
    .rs1_zimm   (rs1_zimm),
    .rs1_data   (rs1_data),
    .csr_out    (csr_out),
    .timer_irq  (timer_irq),
    .timer_clear(timer_clear),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_prio   (irq_prio),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .cur_prio   (cur_prio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input csr_op_t op, input zimm_t z, input word_t d,
                           input csr_addr_t a = ADDR);
    csr_enable = 1'b1;
    csr_op     = op;
    csr_addr   = a;
    rs1_zimm   = z;
    rs1_data   = d;
    step();
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
  endtask

  task automatic expect_req(input string tag, input logic [1:0] id, input logic [2:0] pr);
    check({tag, ".req"}, irq_req, 1);
    check({tag, ".id"}, irq_id, id);
    check({tag, ".prio"}, irq_prio, pr);
  endtask

  task automatic do_ack(input string tag, input logic [3:0] clr, input logic [2:0] cur);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check({tag, ".ack_req"}, irq_req, 0);
    check({tag, ".ack_clr"}, timer_clear, clr);
    check({tag, ".ack_cur"}, cur_prio, cur);
    step();
    check({tag, ".clr_pulse"}, timer_clear, 0);
  endtask

  task automatic do_ret(input string tag, input logic [2:0] cur);
    irq_ret = 1'b1;
    step();
    irq_ret = 1'b0;
    check({tag, ".ret_cur"}, cur_prio, cur);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    csr_enable = 1'b0;
    csr_addr   = ADDR;
    csr_op     = CSR_NONE;
    rs1_zimm   = '0;
    rs1_data   = '0;
    timer_irq  = '0;
    irq_ack    = 1'b0;
    irq_ret    = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst.req", irq_req, 0);
    check("rst.id", irq_id, 0);
    check("rst.prio", irq_prio, 0);
    check("rst.clr", timer_clear, 0);
    check("rst.cur", cur_prio, 0);
    check("rst.csr", csr_out, 0);

    // CSR write, and a write to another address that must be ignored
    csr_write(CSR_RW, 5'h1F, 32'h0000_000A);
    check("csr.rw", csr_out, 32'hA);
    csr_write(CSR_RW, 5'h1F, 32'h0000_0FFF, 12'h7C1);
    check("csr.other_addr", csr_out, 32'hA);

    // Basic request: T1 prio 1, two-cycle latency
    timer_irq[1] = 1'b1;
    step();
    check("basic.lat1", irq_req, 0);
    step();
    expect_req("basic", 2'd1, 3'd1);
    step(2);
    expect_req("basic.hold", 2'd1, 3'd1);
    do_ack("basic", 4'b0010, 3'd1);
    check("basic.no_rereq", irq_req, 0);
    timer_irq = '0;
    do_ret("basic", 3'd0);
    do_ret("basic.empty", 3'd0);

    // Tie-break: T0 and T2 both prio 3 (T1=1, T3=2)
    csr_write(CSR_RW, 5'h1F, 32'h0000_04CB);
    timer_irq = 4'b0101;
    step(2);
    expect_req("tie.first", 2'd0, 3'd3);
    do_ack("tie.first", 4'b0001, 3'd3);
    check("tie.masked", irq_req, 0);
    do_ret("tie", 3'd0);
    check("tie.ret_lat", irq_req, 0);
    step();
    expect_req("tie.second", 2'd2, 3'd3);
    do_ack("tie.second", 4'b0100, 3'd3);
    do_ret("tie.second", 3'd0);
    timer_irq = '0;
    step();

    // Preemption and masking: T0=2, T1=1, T3=2
    csr_write(CSR_RW, 5'h1F, 32'h0000_04CA);
    timer_irq[1] = 1'b1;
    step(2);
    expect_req("pre.t1", 2'd1, 3'd1);
    do_ack("pre.t1", 4'b0010, 3'd1);
    timer_irq[0] = 1'b1;
    step(2);
    expect_req("pre.t0", 2'd0, 3'd2);
    do_ack("pre.t0", 4'b0001, 3'd2);
    timer_irq[3] = 1'b1;
    step(3);
    check("pre.t3_masked", irq_req, 0);
    do_ret("pre.t0", 3'd1);
    check("pre.ret_lat", irq_req, 0);
    step();
    expect_req("pre.t3", 2'd3, 3'd2);
    // Ack and return together: depth stays 1, top becomes irq_prio
    irq_ack = 1'b1;
    irq_ret = 1'b1;
    step();
    irq_ack = 1'b0;
    irq_ret = 1'b0;
    check("simul.cur", cur_prio, 3'd2);
    check("simul.clr", timer_clear, 4'b1000);
    check("simul.req", irq_req, 0);
    do_ret("simul", 3'd0);
    timer_irq = '0;
    step();

    // Stack full: nest prios 1..4, then a prio-5 source must wait for a return
    csr_write(CSR_RW, 5'h1F, 32'h0000_08D1);
    for (int i = 0; i < 4; i++) begin
      timer_irq[i] = 1'b1;
      step(2);
      expect_req($sformatf("full.nest%0d", i), 2'(i), 3'(i + 1));
      do_ack($sformatf("full.nest%0d", i), 4'(1 << i), 3'(i + 1));
    end
    csr_write(CSR_RW, 5'h1F, 32'h0000_08D5);
    timer_irq[0] = 1'b0;
    step();
    timer_irq[0] = 1'b1;
    step(4);
    check("full.blocked", irq_req, 0);
    do_ret("full", 3'd3);
    step();
    expect_req("full.after_ret", 2'd0, 3'd5);
    do_ack("full.after_ret", 4'b0001, 3'd5);
    for (int i = 0; i < 4; i++) begin
      do_ret($sformatf("full.unwind%0d", i), 3'(3 - i));
    end
    timer_irq = '0;
    step();

    // CSR set/clear with immediates, disable and re-enable a pending source
    csr_write(CSR_RW, 5'h00, 32'h0000_0000);
    check("csr.clear", csr_out, 0);
    csr_write(CSR_RSI, 5'h03, 32'hFFFF_FFFF);
    check("csr.rsi", csr_out, 32'h3);
    csr_write(CSR_RCI, 5'h01, 32'hFFFF_FFFF);
    check("csr.rci", csr_out, 32'h2);
    csr_write(CSR_RC, 5'h1F, 32'h0000_0002);
    check("csr.rc", csr_out, 0);
    timer_irq[0] = 1'b1;
    step(3);
    check("csr.disabled", irq_req, 0);
    csr_write(CSR_RS, 5'h1F, 32'h0000_0003);
    check("csr.rs", csr_out, 32'h3);
    check("csr.old_value", irq_req, 0);
    step();
    expect_req("csr.reenable", 2'd0, 3'd3);
    csr_write(CSR_RWI, 5'h07, 32'h0000_0000);
    expect_req("csr.frozen", 2'd0, 3'd3);
    do_ack("csr.frozen", 4'b0001, 3'd3);
    do_ret("csr.frozen", 3'd0);
    timer_irq = '0;
    step();

    // Asynchronous reset mid-request, then a held source counts as an edge
    csr_write(CSR_RW, 5'h1F, 32'h0000_000A);
    timer_irq[1] = 1'b1;
    step(2);
    expect_req("arst.pre", 2'd1, 3'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst.req", irq_req, 0);
    check("arst.id", irq_id, 0);
    check("arst.prio", irq_prio, 0);
    check("arst.cur", cur_prio, 0);
    check("arst.csr", csr_out, 0);
    step();
    reset = 1'b0;
    csr_write(CSR_RW, 5'h1F, 32'h0000_000A);
    check("arst.lat", irq_req, 0);
    step();
    expect_req("arst.held_edge", 2'd1, 3'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
